axi4_lite_slv_reg_file: RTL

Parametrised AXI4-Lite slave register file: NUM_REGS memory-mapped registers with configurable address/data width, byte-strobe writes, per-register read-only mapping to fabric inputs, and decoupled AW/W acceptance. Sits between the PS/interconnect AXI4-Lite master and fabric control logic. It generalises the fixed 4×32-bit slave template and is the control/status block for new IP.

---
 rtl/axi4_lite_slv_reg_file_pkg.sv | 40 ++++
 rtl/axi4_lite_if.sv | 41 ++++
 rtl/axi4_lite_slv_reg_file_wr_ch.sv | 138 +++++++++++++
 rtl/axi4_lite_slv_reg_file.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_slv_reg_file_pkg.sv
// Shared types, response codes and the byte-lane merge helper for the
// AXI4-Lite slave register file.
package axi4_lite_slv_reg_file_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest supported data bus; the merge helper is sized for it.
    localparam int MAX_DATA_W = 64;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

    // Replace each byte of old_v by the matching byte of new_v where strb_v is set.
    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] old_v,
        input logic [MAX_DATA_W-1:0] new_v,
        input logic [MAX_STRB_W-1:0] strb_v
    );
        logic [MAX_DATA_W-1:0] res_v;
        res_v = old_v;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            if (strb_v[i]) begin
                res_v[i*8 +: 8] = new_v[i*8 +: 8];
            end else begin
                res_v[i*8 +: 8] = old_v[i*8 +: 8];
            end
        end
        return res_v;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with slave and master views.
interface axi4_lite_if #(
    parameter int AXI4_LITE_ADDR_BIT_WIDTH = 8,
    parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
);
    logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]     awaddr;
    logic [2:0]                              awprot;
    logic                                    awvalid;
    logic                                    awready;
    logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]     wdata;
    logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0]   wstrb;
    logic                                    wvalid;
    logic                                    wready;
    logic [1:0]                              bresp;
    logic                                    bvalid;
    logic                                    bready;
    logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]     araddr;
    logic [2:0]                              arprot;
    logic                                    arvalid;
    logic                                    arready;
    logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]     rdata;
    logic [1:0]                              rresp;
    logic                                    rvalid;
    logic                                    rready;

    modport slv_port (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport mst_port (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );
endinterface

// File: rtl/axi4_lite_slv_reg_file_wr_ch.sv
// Write channel: independent one-entry AW and W holds, write FSM and B channel.
// Emits a single-cycle commit strobe with index/data/strobe to the register array.
// Optional macro AXI4_LITE_SLV_REG_FILE_DECERR_EN: out-of-range index answers
// SLVERR and suppresses the commit; otherwise the index wraps modulo NUM_REGS.
module axi4_lite_slv_reg_file_wr_ch
    import axi4_lite_slv_reg_file_pkg::*;
#(
    parameter  int ADDR_W    = 8,
    parameter  int DATA_W    = 32,
    parameter  int NUM_REGS  = 16,
    localparam int STRB_W    = DATA_W / 8,
    localparam int OFF_W     = $clog2(STRB_W),
    localparam int IDX_W     = ADDR_W - OFF_W,
    localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                 clk_i,
    input  logic                 sync_rst_i,
    input  logic [IDX_W-1:0]     aw_idx_i,
    input  logic                 awvalid_i,
    output logic                 awready_o,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic [STRB_W-1:0]    wstrb_i,
    input  logic                 wvalid_i,
    output logic                 wready_o,
    output logic [1:0]           bresp_o,
    output logic                 bvalid_o,
    input  logic                 bready_i,
    output logic                 commit_o,
    output logic [REG_IDX_W-1:0] commit_idx_o,
    output logic [DATA_W-1:0]    commit_data_o,
    output logic [STRB_W-1:0]    commit_strb_o
);

    localparam logic [31:0] NUM_REGS_U = NUM_REGS;

    wr_state_e             wr_state_q;
    logic                  aw_full_q;
    logic                  aw_full_d;
    logic                  w_full_q;
    logic                  w_full_d;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  commit_s;
    logic                  oob_s;
    logic [31:0]           idx_ext_s;
    logic [REG_IDX_W-1:0]  idx_s;

    // Handshakes, commit condition and next-state of the two holds.
    always_comb begin
        aw_hs_s  = awvalid_i && awready_q;
        w_hs_s   = wvalid_i && wready_q;
        commit_s = (wr_state_q == WR_IDLE) && aw_full_q && w_full_q;
        if (commit_s) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end else begin
            aw_full_d = aw_full_q || aw_hs_s;
            w_full_d  = w_full_q || w_hs_s;
        end
    end

    // Map the held address index onto a register, flagging out-of-range targets.
    always_comb begin
        idx_ext_s = 32'(aw_idx_q);
`ifdef AXI4_LITE_SLV_REG_FILE_DECERR_EN
        oob_s = (idx_ext_s >= NUM_REGS_U);
        idx_s = REG_IDX_W'(idx_ext_s);
`else
        oob_s = 1'b0;
        idx_s = REG_IDX_W'(idx_ext_s % NUM_REGS_U);
`endif
    end

    // Holds, ready flags, write FSM and B channel outputs.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            wr_state_q <= WR_IDLE;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            awready_q <= !aw_full_d;
            wready_q  <= !w_full_d;
            if (aw_hs_s) begin
                aw_idx_q <= aw_idx_i;
            end
            if (w_hs_s) begin
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
            end
            case (wr_state_q)
                WR_IDLE: begin
                    if (commit_s) begin
                        bvalid_q   <= 1'b1;
                        bresp_q    <= oob_s ? RESP_SLVERR : RESP_OKAY;
                        wr_state_q <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bready_i) begin
                        bvalid_q   <= 1'b0;
                        wr_state_q <= WR_IDLE;
                    end
                end
                default: begin
                    bvalid_q   <= 1'b0;
                    wr_state_q <= WR_IDLE;
                end
            endcase
        end
    end

    assign awready_o     = awready_q;
    assign wready_o      = wready_q;
    assign bvalid_o      = bvalid_q;
    assign bresp_o       = bresp_q;
    assign commit_o      = commit_s && !oob_s;
    assign commit_idx_o  = idx_s;
    assign commit_data_o = wdata_q;
    assign commit_strb_o = wstrb_q;

endmodule

// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite slave register file: NUM_REGS registers with byte-strobe writes,
// read-only slots fed from fabric, independent read and write paths.
// Optional macro AXI4_LITE_SLV_REG_FILE_DECERR_EN: out-of-range accesses answer
// SLVERR with zero read data; without it the index wraps modulo NUM_REGS.
module axi4_lite_slv_reg_file
    import axi4_lite_slv_reg_file_pkg::*;
#(
    parameter int                  AXI4_LITE_ADDR_BIT_WIDTH = 8,
    parameter int                  AXI4_LITE_DATA_BIT_WIDTH = 32,
    parameter int                  NUM_REGS                 = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK                  = '0
) (
    input  logic                                         i_clk,
    input  logic                                         i_sync_rst,
    axi4_lite_if.slv_port                                if_s_axi4_lite,
    output logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] o_reg_vals,
    input  logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] i_ro_vals,
    output logic [NUM_REGS-1:0]                          o_wr_pulse
);

    localparam int          ADDR_W     = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int          DATA_W     = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int          STRB_W     = DATA_W / 8;
    localparam int          OFF_W      = $clog2(STRB_W);
    localparam int          IDX_W      = ADDR_W - OFF_W;
    localparam int          REG_IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] NUM_REGS_U = NUM_REGS;

    logic [NUM_REGS*DATA_W-1:0] reg_vals_q;
    logic [NUM_REGS-1:0]        wr_pulse_q;

    logic [IDX_W-1:0]           aw_idx_s;
    logic                       awready_s;
    logic                       wready_s;
    logic                       bvalid_s;
    logic [1:0]                 bresp_s;
    logic                       wr_commit_s;
    logic [REG_IDX_W-1:0]       wr_idx_s;
    logic [DATA_W-1:0]          wr_data_s;
    logic [STRB_W-1:0]          wr_strb_s;
    logic [DATA_W-1:0]          wr_merged_s;

    rd_state_e                  rd_state_q;
    logic                       arready_q;
    logic                       rvalid_q;
    logic [DATA_W-1:0]          rdata_q;
    logic [1:0]                 rresp_q;
    logic [IDX_W-1:0]           ar_idx_s;
    logic [31:0]                rd_idx_ext_s;
    logic [REG_IDX_W-1:0]       rd_idx_s;
    logic                       rd_oob_s;
    logic [DATA_W-1:0]          rd_data_s;

    // Byte-offset bits and protection attributes carry no meaning here.
    logic unused_s;
    assign unused_s = ^{if_s_axi4_lite.awaddr[OFF_W-1:0], if_s_axi4_lite.araddr[OFF_W-1:0],
                        if_s_axi4_lite.awprot, if_s_axi4_lite.arprot};

    assign aw_idx_s = if_s_axi4_lite.awaddr[ADDR_W-1:OFF_W];
    assign ar_idx_s = if_s_axi4_lite.araddr[ADDR_W-1:OFF_W];

    axi4_lite_slv_reg_file_wr_ch #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_wr_ch (
        .clk_i         (i_clk),
        .sync_rst_i    (i_sync_rst),
        .aw_idx_i      (aw_idx_s),
        .awvalid_i     (if_s_axi4_lite.awvalid),
        .awready_o     (awready_s),
        .wdata_i       (if_s_axi4_lite.wdata),
        .wstrb_i       (if_s_axi4_lite.wstrb),
        .wvalid_i      (if_s_axi4_lite.wvalid),
        .wready_o      (wready_s),
        .bresp_o       (bresp_s),
        .bvalid_o      (bvalid_s),
        .bready_i      (if_s_axi4_lite.bready),
        .commit_o      (wr_commit_s),
        .commit_idx_o  (wr_idx_s),
        .commit_data_o (wr_data_s),
        .commit_strb_o (wr_strb_s)
    );

    // New value of the committed register after the byte-lane merge.
    always_comb begin
        wr_merged_s = DATA_W'(merge_bytes(MAX_DATA_W'(reg_vals_q[wr_idx_s*DATA_W +: DATA_W]),
                                          MAX_DATA_W'(wr_data_s),
                                          MAX_STRB_W'(wr_strb_s)));
    end

    // Register array update and one-cycle write pulse; read-only slots never change.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            reg_vals_q <= '0;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (wr_commit_s && !RO_MASK[wr_idx_s]) begin
                reg_vals_q[wr_idx_s*DATA_W +: DATA_W] <= wr_merged_s;
                wr_pulse_q[wr_idx_s]                  <= 1'b1;
            end
        end
    end

    // Read index decode and source selection (array, fabric input, or zero).
    always_comb begin
        rd_idx_ext_s = 32'(ar_idx_s);
`ifdef AXI4_LITE_SLV_REG_FILE_DECERR_EN
        rd_oob_s = (rd_idx_ext_s >= NUM_REGS_U);
        rd_idx_s = REG_IDX_W'(rd_idx_ext_s);
`else
        rd_oob_s = 1'b0;
        rd_idx_s = REG_IDX_W'(rd_idx_ext_s % NUM_REGS_U);
`endif
        if (rd_oob_s) begin
            rd_data_s = '0;
        end else if (RO_MASK[rd_idx_s]) begin
            rd_data_s = i_ro_vals[rd_idx_s*DATA_W +: DATA_W];
        end else begin
            rd_data_s = reg_vals_q[rd_idx_s*DATA_W +: DATA_W];
        end
    end

    // Read FSM: accept one AR, hold R until the master takes it.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (if_s_axi4_lite.arvalid && arready_q) begin
                        rdata_q    <= rd_data_s;
                        rresp_q    <= rd_oob_s ? RESP_SLVERR : RESP_OKAY;
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        rd_state_q <= RD_RESP;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (if_s_axi4_lite.rready) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= RD_IDLE;
                    end
                end
                default: begin
                    rvalid_q   <= 1'b0;
                    arready_q  <= 1'b0;
                    rd_state_q <= RD_IDLE;
                end
            endcase
        end
    end

    assign if_s_axi4_lite.awready = awready_s;
    assign if_s_axi4_lite.wready  = wready_s;
    assign if_s_axi4_lite.bvalid  = bvalid_s;
    assign if_s_axi4_lite.bresp   = bresp_s;
    assign if_s_axi4_lite.arready = arready_q;
    assign if_s_axi4_lite.rvalid  = rvalid_q;
    assign if_s_axi4_lite.rdata   = rdata_q;
    assign if_s_axi4_lite.rresp   = rresp_q;
    assign o_reg_vals             = reg_vals_q;
    assign o_wr_pulse             = wr_pulse_q;

endmodule
